// File: rtl/int_divider.sv
// Iterative radix-2 restoring integer divider with signed/unsigned
// quotient and remainder, divide-by-zero and signed-overflow shortcuts.
module int_divider #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  dvs_q;
  logic              q_neg, r_neg, is_rem_q;
  logic [WIDTH-1:0]  result_q;
  logic              dbz_q;

  logic              accept, div_zero, sovf, last;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [WIDTH:0]    shifted, diff;
  logic              qbit;
  logic [WIDTH-1:0]  quo_nxt, rem_nxt, q_fin, r_fin;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q & out_valid;

  assign accept   = in_valid & in_ready & ~flush;
  assign div_zero = (divisor == '0);
  assign sovf     = ~op[0] & (dividend == MIN_NEG) & (divisor == '1);
  assign last     = (cnt == LAST);

  assign a_neg = ~op[0] & dividend[WIDTH-1];
  assign b_neg = ~op[0] & divisor[WIDTH-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor  : divisor;

  // one restoring step: the partial remainder is WIDTH+1 bits wide while
  // the stored remainder always fits WIDTH bits after restoring
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], qbit};
    q_fin   = q_neg ? -quo_nxt : quo_nxt;
    r_fin   = r_neg ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (div_zero || sovf) ? DONE : BUSY;
      BUSY: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            rem_q    <= '0;
            is_rem_q <= op[1];
            if (div_zero) begin
              result_q <= op[1] ? dividend : '1;
              dbz_q    <= 1'b1;
            end else if (sovf) begin
              result_q <= op[1] ? '0 : dividend;
              dbz_q    <= 1'b0;
            end else begin
              quo_q <= a_abs;
              dvs_q <= b_abs;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              dbz_q <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt + 1'b1;
            if (last) begin
              result_q <= is_rem_q ? r_fin : q_fin;
              cnt      <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_divider.sv
// Directed-vector bench for int_divider at WIDTH=64.
module tb_int_divider;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
  localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  int_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called at a negedge; request is accepted on the following posedge
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    check("accept_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
  endtask

  // latency = edges after the accept edge up to the first edge seeing out_valid
  task automatic await(input string tag, input logic [W-1:0] exp, input logic exp_dbz, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, "_lat"}, W'(lat), W'(exp_lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_dbz"}, W'(div_by_zero), W'(exp_dbz));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rdy"}, W'(in_ready), 1);
    check({tag, "_ov0"}, W'(out_valid), 0);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input logic exp_dbz,
                     input int exp_lat);
    issue(o, a, b);
    await(tag, exp, exp_dbz, exp_lat);
    retire(tag);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(tag, W'(seen), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_ready", W'(in_ready), 1);
    check("rst_ovalid", W'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_dbz", W'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // first accept on the first edge after release; result held 10 cycles
    issue(DIVU, 64'd100, 64'd7);
    await("divu100_7", 64'd14, 1'b0, 65);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ov", W'(out_valid), 1);
      check("hold_res", result, 64'd14);
      check("hold_rdy", W'(in_ready), 0);
    end
    // release and present a new request on the same edge: must not be taken
    out_ready = 1'b1; in_valid = 1'b1; op = DIVU; dividend = 64'd50; divisor = 64'd3;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_rdy", W'(in_ready), 1);
    check("b2b_ov", W'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_taken", W'(in_ready), 0);
    await("b2b", 64'd16, 1'b0, 65);
    retire("b2b");

    run("div_m7_2",  DIV,  -64'sd7, 64'd2,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
    run("rem_m7_2",  REM,  -64'sd7, 64'd2,  ONES,                    1'b0, 65);
    run("remu_7_m2", REMU, 64'd7,  -64'sd2, 64'd7,                   1'b0, 65);
    run("div_7_m2",  DIV,  64'd7,  -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
    run("rem_7_m2",  REM,  64'd7,  -64'sd2, 64'd1,                   1'b0, 65);
    run("div_m8_m3", DIV,  -64'sd8, -64'sd3, 64'd2,                  1'b0, 65);
    run("rem_m8_m3", REM,  -64'sd8, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);
    run("divu_max_1", DIVU, ONES, 64'd1,    ONES,                    1'b0, 65);
    run("remu_max_10", REMU, ONES, 64'd10,  64'd5,                   1'b0, 65);
    run("divu_3_5",  DIVU, 64'd3,  64'd5,   64'd0,                   1'b0, 65);
    run("div_min_2", DIV,  MINV,   64'd2,   64'hC000_0000_0000_0000, 1'b0, 65);
    run("divu_5_0",  DIVU, 64'd5,  64'd0,   ONES,                    1'b1, 1);
    run("rem_m5_0",  REM,  -64'sd5, 64'd0,  64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1);
    run("div_ovf",   DIV,  MINV,   ONES,    MINV,                    1'b0, 1);
    run("rem_ovf",   REM,  MINV,   ONES,    64'd0,                   1'b0, 1);

    // flush on BUSY cycle 20
    issue(DIVU, 64'd1000, 64'd3);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_rdy", W'(in_ready), 1);
    check("flush_busy_ov", W'(out_valid), 0);
    watch_quiet("flush_busy_quiet", 80);

    // flush in IDLE blocks acceptance
    flush = 1'b1; in_valid = 1'b1; op = DIVU; dividend = 64'd9; divisor = 64'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_rdy", W'(in_ready), 1);
    watch_quiet("flush_idle_quiet", 5);

    // flush wins over out_ready in DONE
    @(negedge clk);
    issue(DIVU, 64'd5, 64'd0);
    await("flush_done_pre", ONES, 1'b1, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_ov", W'(out_valid), 0);
    check("flush_done_rdy", W'(in_ready), 1);

    // asynchronous reset mid-BUSY, away from any clock edge
    @(negedge clk);
    issue(DIV, -64'sd7, 64'd2);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov", W'(out_valid), 0);
    check("arst_res", result, 0);
    check("arst_rdy", W'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("arst_quiet", 80);

    run("post_rst", REMU, 64'd100, 64'd7, 64'd2, 1'b0, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_divider.md
INT_DIVIDER -- requirements
Module: int_divider

Interface
REQ-001 Parameter WIDTH, default 64, sets the operand and result bit-width.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  divider can accept a request.
REQ-006 op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-007 dividend  input  WIDTH  numerator.
REQ-008 divisor  input  WIDTH  denominator.
REQ-009 flush  input  1  synchronous abort of the in-flight operation.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  quotient or remainder, as selected by op.
REQ-013 div_by_zero  output  1  the current result came from a zero divisor; valid only while out_valid=1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; op, dividend and divisor SHALL be captured on that edge.
REQ-017 On accept with divisor=0, the FSM SHALL go IDLE->DONE with div_by_zero=1 and result as follows:
- DIV/DIVU: all ones.
- REM/REMU: the dividend.
REQ-018 On accept of signed overflow (DIV/REM, dividend=1 followed by WIDTH-1 zeros, divisor=all ones), the FSM SHALL go IDLE->DONE with div_by_zero=0 and result as follows:
- DIV: the dividend.
- REM: 0.
REQ-019 On any other accept, the FSM SHALL go IDLE->BUSY and latch operand magnitudes (two's-complement absolute value for DIV/REM, raw value for DIVU/REMU).
REQ-020 BUSY SHALL run radix-2 restoring division, one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
- An iteration counter runs 0..WIDTH-1.
- The partial remainder is WIDTH+1 bits wide.
REQ-021 On the final BUSY cycle, the FSM SHALL go BUSY->DONE and register the sign-corrected result:
- Quotient is negated iff the op is signed and the operand signs differ.
- Remainder takes the sign of the dividend.
- Remainder satisfies |remainder| < |divisor|.
REQ-022 Latency from the accept edge to out_valid=1 SHALL be exactly 1 cycle for REQ-017/REQ-018 cases and exactly WIDTH+1 cycles otherwise.
REQ-023 In DONE, out_valid SHALL be 1, and result and div_by_zero SHALL hold stable until a rising edge with out_ready=1.
REQ-024 A rising edge in DONE with out_ready=1 SHALL move the FSM DONE->IDLE, so in_ready=1 on the next cycle; a new request SHALL NOT be accepted on that same edge.
REQ-025 flush=1 on a rising edge in BUSY or DONE SHALL force IDLE on that edge and discard the result.
REQ-026 flush has priority over out_ready and over iteration completion.
REQ-027 flush=1 in IDLE SHALL block acceptance on that edge.
REQ-028 out_valid SHALL never be 1 in IDLE or BUSY.
REQ-029 Operands SHALL be treated as unchanged after accept: input changes during BUSY/DONE SHALL NOT affect result.

Reset
REQ-030 While rst_n=0, regardless of clk, the block SHALL immediately force:
- state to IDLE;
- out_valid, result, div_by_zero and the iteration counter to 0;
- in_ready to 1.
REQ-031 Reset asserted mid-BUSY or in DONE SHALL abandon the operation with no out_valid pulse after release.
REQ-032 The first accept SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-033 Test: WIDTH=64, DIVU 100/7 -> result 14, div_by_zero=0, out_valid first high exactly 65 cycles after the accept edge.
REQ-034 Test: DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); REMU 7/-2 -> 7.
REQ-035 Test: DIVU 5/0 -> all ones and div_by_zero=1, 1-cycle latency; REM -5/0 -> -5 and div_by_zero=1.
REQ-036 Test: DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; REM with the same operands -> 0; both with 1-cycle latency.
REQ-037 Test: hold out_ready=0 for 10 cycles in DONE -> out_valid, result and in_ready=0 stay stable; then pulse out_ready -> in_ready=1 on the next cycle, and a back-to-back request is accepted.
REQ-038 Test: flush on BUSY cycle 20 -> no out_valid, in_ready=1 next cycle; rst_n=0 mid-BUSY -> out_valid=0 and result=0 without waiting for a clock edge, with no output after release.
